// File: rtl/vga_pattern_pipe.sv
// Pixel-rendering stage behind the VGA timing generator: four test patterns,
// fixed two-cycle pipeline with the syncs delayed to stay aligned with colour.
module vga_pattern_pipe #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BOX_SIZE = 32,
    parameter int BAR_W    = 80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] pixelx,
    input  logic [10:0] pixely,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic [1:0]  mode,
    output logic        r,
    output logic        g,
    output logic        b,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de_o
);

    localparam int BCW = $clog2(BAR_W);

    logic           active;
    logic           in_box;
    logic           frame_tick;
    logic [11:0]    box_x_end;
    logic [11:0]    box_y_end;
    logic [2:0]     colour;

    logic           active_s1;
    logic           checker_s1;
    logic           in_box_s1;
    logic           hsync_s1;
    logic           vsync_s1;

    logic [BCW-1:0] bar_cnt;
    logic [2:0]     bar_idx;
    logic [10:0]    box_x;
    logic [10:0]    box_y;
    logic           dir_x;
    logic           dir_y;
    logic [7:0]     frame_cnt;
    logic [1:0]     mode_q;

    // Box bounds are widened to 12 bits so box + BOX_SIZE can never wrap.
    assign box_x_end  = {1'b0, box_x} + 12'(BOX_SIZE);
    assign box_y_end  = {1'b0, box_y} + 12'(BOX_SIZE);
    assign in_box     = ({1'b0, pixelx} >= {1'b0, box_x}) && ({1'b0, pixelx} < box_x_end) &&
                        ({1'b0, pixely} >= {1'b0, box_y}) && ({1'b0, pixely} < box_y_end);
    assign active     = (pixelx < 11'(H_ACTIVE)) && (pixely < 11'(V_ACTIVE));
    assign frame_tick = (pixelx == 11'd0) && (pixely == 11'(V_ACTIVE));

    always_comb begin
        colour = 3'b000;
        case (mode_q)
            2'd0:    colour = {3{checker_s1}};
            2'd1:    colour = 3'b111 - bar_idx;
            2'd2:    colour = in_box_s1 ? 3'b111 : 3'b001;
            default: colour = frame_cnt[7:5];
        endcase
        if (!active_s1) begin
            colour = 3'b000;
        end
    end

    // Sync delay registers load the live inputs during reset so the pins never glitch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            active_s1  <= 1'b0;
            checker_s1 <= 1'b0;
            in_box_s1  <= 1'b0;
            hsync_s1   <= hsync_i;
            vsync_s1   <= vsync_i;
            r          <= 1'b0;
            g          <= 1'b0;
            b          <= 1'b0;
            de_o       <= 1'b0;
            hsync_o    <= hsync_i;
            vsync_o    <= vsync_i;
        end else begin
            active_s1  <= active;
            checker_s1 <= pixelx[4] ^ pixely[4];
            in_box_s1  <= in_box;
            hsync_s1   <= hsync_i;
            vsync_s1   <= vsync_i;
            {r, g, b}  <= colour;
            de_o       <= active_s1;
            hsync_o    <= hsync_s1;
            vsync_o    <= vsync_s1;
        end
    end

    // Bar index tracks pixelx/BAR_W by counting; the frame tick falls in blanking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bar_cnt   <= '0;
            bar_idx   <= 3'd0;
            box_x     <= 11'd0;
            box_y     <= 11'd0;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            frame_cnt <= 8'd0;
            mode_q    <= 2'd0;
        end else begin
            if (pixelx == 11'd0) begin
                bar_cnt <= '0;
                bar_idx <= 3'd0;
            end else if (pixelx < 11'(H_ACTIVE)) begin
                if (bar_cnt == BCW'(BAR_W - 1)) begin
                    bar_cnt <= '0;
                    if (bar_idx != 3'd7) begin
                        bar_idx <= bar_idx + 3'd1;
                    end
                end else begin
                    bar_cnt <= bar_cnt + BCW'(1);
                end
            end

            if (frame_tick) begin
                frame_cnt <= frame_cnt + 8'd1;
                mode_q    <= mode;
                if (dir_x) begin
                    if (box_x == 11'(H_ACTIVE - BOX_SIZE)) begin
                        dir_x <= 1'b0;
                        box_x <= box_x - 11'd1;
                    end else begin
                        box_x <= box_x + 11'd1;
                    end
                end else if (box_x == 11'd0) begin
                    dir_x <= 1'b1;
                    box_x <= 11'd1;
                end else begin
                    box_x <= box_x - 11'd1;
                end
                if (dir_y) begin
                    if (box_y == 11'(V_ACTIVE - BOX_SIZE)) begin
                        dir_y <= 1'b0;
                        box_y <= box_y - 11'd1;
                    end else begin
                        box_y <= box_y + 11'd1;
                    end
                end else if (box_y == 11'd0) begin
                    dir_y <= 1'b1;
                    box_y <= 11'd1;
                end else begin
                    box_y <= box_y - 11'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_pattern_pipe.sv
// Directed self-checking bench for vga_pattern_pipe; outputs are sampled as
// {r,g,b,de_o,hsync_o,vsync_o} on the falling edge before new inputs are driven.
module tb_vga_pattern_pipe;

    logic        clk;
    logic        rst;
    logic [10:0] pixelx;
    logic [10:0] pixely;
    logic        hsync_i;
    logic        vsync_i;
    logic [1:0]  mode;
    logic        r;
    logic        g;
    logic        b;
    logic        hsync_o;
    logic        vsync_o;
    logic        de_o;

    logic        rst_next;
    logic [5:0]  obs;
    int          tests;
    int          failed;

    vga_pattern_pipe dut (
        .clk     (clk),
        .rst     (rst),
        .pixelx  (pixelx),
        .pixely  (pixely),
        .hsync_i (hsync_i),
        .vsync_i (vsync_i),
        .mode    (mode),
        .r       (r),
        .g       (g),
        .b       (b),
        .hsync_o (hsync_o),
        .vsync_o (vsync_o),
        .de_o    (de_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Samples the outputs left by the previous edges, then drives the next inputs.
    task automatic cycle(input int x, input int y, input logic hs, input logic vs);
        @(negedge clk);
        obs     = {r, g, b, de_o, hsync_o, vsync_o};
        rst     = rst_next;
        pixelx  = 11'(x);
        pixely  = 11'(y);
        hsync_i = hs;
        vsync_i = vs;
    endtask

    task automatic probe(input int x, input int y, output logic [5:0] o);
        cycle(x, y, 1'b1, 1'b1);
        cycle(700, 500, 1'b1, 1'b1);
        cycle(700, 500, 1'b1, 1'b1);
        o = obs;
    endtask

    task automatic do_reset();
        rst_next = 1'b0;
        cycle(700, 500, 1'b1, 1'b1);
        cycle(700, 500, 1'b1, 1'b1);
        rst_next = 1'b1;
    endtask

    task automatic frame_updates(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(0, 480, 1'b1, 1'b1);
        end
    endtask

    task automatic test_reset();
        logic [5:0] exp_seq[4] = '{6'b000011, 6'b000011, 6'b000111, 6'b000111};
        mode     = 2'd0;
        rst_next = 1'b0;
        cycle(700, 500, 1'b0, 1'b1);
        cycle(700, 500, 1'b1, 1'b1);
        tests++;
        if (obs !== 6'b000001) begin
            failed++;
            $display("[TB] FAIL reset_sync_live got %b want %b", obs, 6'b000001);
        end
        for (int i = 0; i < 3; i++) cycle(700, 500, 1'b1, 1'b1);
        rst_next = 1'b1;
        for (int x = 0; x < 4; x++) begin
            cycle(x, 0, 1'b1, 1'b1);
            tests++;
            if (obs !== exp_seq[x]) begin
                failed++;
                $display("[TB] FAIL reset_release_step%0d got %b want %b", x, obs, exp_seq[x]);
            end
        end
    endtask

    task automatic test_checker();
        int         xm;
        logic       c;
        logic [5:0] e;
        mode = 2'd0;
        for (int x = 0; x <= 42; x++) begin
            cycle(x, 0, 1'b1, 1'b1);
            if (x >= 2) begin
                xm = x - 2;
                c  = xm[4];
                e  = {c, c, c, 3'b111};
                tests++;
                if (obs !== e) begin
                    failed++;
                    $display("[TB] FAIL checker_x%0d got %b want %b", xm, obs, e);
                end
            end
        end
        for (int x = 650; x <= 665; x++) begin
            cycle(x, 0, (x == 656) ? 1'b0 : 1'b1, 1'b1);
            if (x >= 652) begin
                e = {4'b0000, (x == 658) ? 1'b0 : 1'b1, 1'b1};
                tests++;
                if (obs !== e) begin
                    failed++;
                    $display("[TB] FAIL hsync_x%0d got %b want %b", x - 2, obs, e);
                end
            end
        end
    endtask

    task automatic test_bars();
        int         xm;
        logic [2:0] col;
        logic [5:0] e;
        mode = 2'd1;
        frame_updates(1);
        for (int x = 0; x <= 801; x++) begin
            cycle(x, 10, 1'b1, 1'b1);
            if (x >= 2) begin
                xm = x - 2;
                if (xm < 640) begin
                    col = 3'(7 - xm / 80);
                    e   = {col, 3'b111};
                end else begin
                    e = 6'b000011;
                end
                tests++;
                if (obs !== e) begin
                    failed++;
                    $display("[TB] FAIL bars_x%0d got %b want %b", xm, obs, e);
                end
            end
        end
    endtask

    task automatic test_box();
        int         xs[19] = '{0, 1, 32, 33, 5, 1, 1,
                              608, 607, 639, 608, 608, 608,
                              607, 606, 638, 639, 607, 607};
        int         ys[19] = '{1, 1, 1, 1, 0, 32, 33,
                              288, 288, 288, 287, 319, 320,
                              287, 287, 287, 287, 318, 319};
        logic [5:0] es[19] = '{6'b001111, 6'b111111, 6'b111111, 6'b001111, 6'b001111, 6'b111111, 6'b001111,
                              6'b111111, 6'b001111, 6'b111111, 6'b001111, 6'b111111, 6'b001111,
                              6'b111111, 6'b001111, 6'b111111, 6'b001111, 6'b111111, 6'b001111};
        logic [5:0] o;
        do_reset();
        mode = 2'd2;
        for (int i = 0; i < 19; i++) begin
            if (i == 7) frame_updates(607);
            else if (i == 0) frame_updates(1);
            else if (i == 13) frame_updates(1);
            probe(xs[i], ys[i], o);
            tests++;
            if (o !== es[i]) begin
                failed++;
                $display("[TB] FAIL box_%0d_%0d got %b want %b", xs[i], ys[i], o, es[i]);
            end
        end
    endtask

    task automatic test_flood();
        int         xs[8]  = '{16, 0, 16, 16, 16, 700, 10, 16};
        int         ys[8]  = '{100, 100, 5, 5, 5, 10, 490, 5};
        int         upd[8] = '{0, 0, 1, 31, 223, 0, 0, 1};
        logic [5:0] es[8]  = '{6'b111111, 6'b000111, 6'b000111, 6'b001111,
                               6'b111111, 6'b000011, 6'b000011, 6'b000111};
        logic [5:0] o;
        do_reset();
        mode = 2'd3;
        for (int i = 0; i < 8; i++) begin
            frame_updates(upd[i]);
            probe(xs[i], ys[i], o);
            tests++;
            if (o !== es[i]) begin
                failed++;
                $display("[TB] FAIL flood_%0d_%0d_step%0d got %b want %b", xs[i], ys[i], i, o, es[i]);
            end
        end
    endtask

    task automatic test_midline_reset();
        int         xm;
        logic       c;
        logic [5:0] e;
        int         xs[4] = '{1, 0, 33, 260};
        int         ys[4] = '{1, 1, 1, 260};
        logic [5:0] es[4] = '{6'b111111, 6'b001111, 6'b001111, 6'b001111};
        logic [5:0] o;
        mode = 2'd2;
        frame_updates(3);
        for (int x = 296; x <= 312; x++) begin
            rst_next = (x == 300) ? 1'b0 : 1'b1;
            cycle(x, 16, 1'b1, 1'b1);
            if (x >= 298) begin
                xm = x - 2;
                c  = ~xm[4];
                if (x <= 300)      e = 6'b001111;
                else if (x <= 302) e = 6'b000011;
                else               e = {c, c, c, 3'b111};
                tests++;
                if (obs !== e) begin
                    failed++;
                    $display("[TB] FAIL midreset_x%0d got %b want %b", xm, obs, e);
                end
            end
        end
        rst_next = 1'b1;
        frame_updates(1);
        for (int i = 0; i < 4; i++) begin
            probe(xs[i], ys[i], o);
            tests++;
            if (o !== es[i]) begin
                failed++;
                $display("[TB] FAIL midreset_box_%0d_%0d got %b want %b", xs[i], ys[i], o, es[i]);
            end
        end
    endtask

    initial begin
        tests    = 0;
        failed   = 0;
        rst      = 1'b0;
        rst_next = 1'b0;
        pixelx   = 11'd700;
        pixely   = 11'd500;
        hsync_i  = 1'b1;
        vsync_i  = 1'b1;
        mode     = 2'd0;
        test_reset();
        test_checker();
        test_bars();
        test_box();
        test_flood();
        test_midline_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired after %0d tests", tests);
        $fatal(1);
    end

endmodule

// File: doc/vga_pattern_pipe.md
Name: vga_pattern_pipe

Overview:
- Pixel-rendering stage directly downstream of the VGA timing generator. It consumes the generator's pixel coordinates and sync pulses and produces 1-bit R/G/B plus re-timed syncs for the output pins.
- Four test patterns, including a bouncing box that moves once per frame.
- Fixed 2-cycle pipeline, with syncs delayed to stay aligned with colour.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- BOX_SIZE, 32, bouncing-box edge in pixels
- BAR_W, 80, colour-bar width in pixels (H_ACTIVE/8)

Ports:
- clk  in  1  25 MHz pixel clock
- rst  in  1  synchronous reset, active-low
- pixelx  in  11  current pixel column from timing generator, 0..H_TOTAL-1, increments each clk
- pixely  in  11  current line, 0..V_TOTAL-1
- hsync_i  in  1  hsync from timing generator, aligned with pixelx/pixely
- vsync_i  in  1  vsync from timing generator
- mode  in  2  pattern select; 0 checker, 1 bars, 2 box, 3 flood
- r  out  1  red, 2 cycles after its coordinates
- g  out  1  green
- b  out  1  blue
- hsync_o  out  1  hsync_i delayed 2 cycles
- vsync_o  out  1  vsync_i delayed 2 cycles
- de_o  out  1  data-enable (active area), aligned with r/g/b

Behaviour:
- Reset (rst==0 at clk edge): r, g, b, de_o = 0.
- Reset: hsync_o and vsync_o take the reset-time hsync_i/vsync_i values, i.e. the delay regs load the live inputs, so there are no glitches.
- Reset: box_x=0, box_y=0, dir_x=1, dir_y=1, frame_cnt=0, mode_q=0, bar_cnt=0, bar_idx=0.
- Reset mid-frame is legal; output resumes correctly from the next pixel.

Stage 1 (cycle n+1):
- Register active = (pixelx<H_ACTIVE)&&(pixely<V_ACTIVE), the sync inputs, and the pattern intermediates:
  - checker = pixelx[4]^pixely[4]
  - in_box = pixelx in [box_x, box_x+BOX_SIZE) AND pixely in [box_y, box_y+BOX_SIZE), using 12-bit compare sums with no overflow
  - bar_idx

Stage 2 (cycle n+2):
- Select colour by mode_q; force r=g=b=0 when !active; de_o=active.
- Colour by mode_q:
  - 0: r=g=b=checker.
  - 1: {r,g,b} = 3'b111 - bar_idx (bar 0 white ... bar 7 black).
  - 2: in_box ? 3'b111 : 3'b001.
  - 3: {r,g,b} = frame_cnt[7:5].

Bar counter:
- pixelx==0 loads bar_cnt=0 and bar_idx=0.
- Otherwise, while pixelx<H_ACTIVE:
  - bar_cnt==BAR_W-1 wraps to 0 and increments bar_idx (saturating at 7).
  - else bar_cnt increments.
- No divider.

Frame update:
- Single-cycle event when pixelx==0 && pixely==V_ACTIVE (first blanking line), so it never occurs during active video.
- frame_cnt+=1, wrapping at 255.
- mode_q<=mode; mode changes mid-frame take effect at the next frame update, so there is no tearing.
- Box X step:
  - dir_x=1 and box_x==H_ACTIVE-BOX_SIZE: dir_x<=0, box_x<=box_x-1.
  - dir_x=1 otherwise: box_x<=box_x+1.
  - dir_x=0 and box_x==0: dir_x<=1, box_x<=1.
  - dir_x=0 otherwise: box_x<=box_x-1.
- Box Y step: same rules against V_ACTIVE-BOX_SIZE.
- Corner hit flips both directions in the same update.

Latency and boundaries:
- Latency is exactly 2 clk for every output relative to its input coordinate/sync.
- Coordinates beyond the active area (blanking) produce black and de_o=0 regardless of mode.

Test Plan:
1. Hold rst=0 for 4 cycles with hsync_i=1 and vsync_i=1 -> r=g=b=de_o=0, hsync_o=vsync_o=1, box_x=box_y=0. Release rst -> first coordinate appears on outputs 2 cycles later.
2. mode=0, drive pixelx 0..40 on line pixely=0 -> r/g/b=0 for x=0..15, 1 for x=16..31, 0 for x=32..40, each 2 cycles late. Pulse on hsync_i at x=656 -> appears on hsync_o at the cycle of x=658.
3. mode=1, scan a full active line -> colours 111,110,...,000 in 80-pixel runs. x=640..799 -> black, de_o=0.
4. mode=2, run 609 frames -> box_x runs 0→608, reverses and reads 607 on frame 610. box_y reverses at 448. Line 0 pixels x=0..31 white, x=32 blue in the first frame.
5. Change mode from 0 to 3 at pixely=100 -> pattern stays checker until the frame update. Next frame shows flood colour frame_cnt[7:5]. After 256 frames frame_cnt wraps to 0.
6. Assert rst mid-line at pixelx=300 for 1 cycle -> outputs black for 2 cycles, box position reset to (0,0), normal rendering afterwards.
